// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path:
// state codes, opcodes, funct fields and ALU control values.
package mips_pkg;

   localparam int ST_BITS = 4;

   typedef logic [ST_BITS-1:0] state_t;

   localparam state_t S_FETCH    = 4'd0;
   localparam state_t S_DECODE   = 4'd1;
   localparam state_t S_MEMADR   = 4'd2;
   localparam state_t S_MEMRD    = 4'd3;
   localparam state_t S_MEMWB    = 4'd4;
   localparam state_t S_MEMWR    = 4'd5;
   localparam state_t S_EXECUTE  = 4'd6;
   localparam state_t S_ALUWB    = 4'd7;
   localparam state_t S_BRANCH   = 4'd8;
   localparam state_t S_ADDIEXEC = 4'd9;
   localparam state_t S_ADDIWB   = 4'd10;
   localparam state_t S_JUMP     = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef logic [1:0] aluop_t;

   localparam aluop_t ALUOP_ADD   = 2'b00;
   localparam aluop_t ALUOP_SUB   = 2'b01;
   localparam aluop_t ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's aluop and the instruction funct field
// onto the 3-bit ALU control code.
module alu_decoder
   import mips_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alu_control,
   output logic       bad_funct
);

   always_comb begin
      alu_control = ALU_ADD;
      bad_funct   = 1'b0;
      case (aluop)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_control = ALU_ADD;
               FN_SUB:  alu_control = ALU_SUB;
               FN_AND:  alu_control = ALU_AND;
               FN_OR:   alu_control = ALU_OR;
               FN_SLT:  alu_control = ALU_SLT;
               default: bad_funct   = 1'b1;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath; sequences
// fetch, decode, execute, memory and writeback for each instruction.
module multicycle_controller
   import mips_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   output logic               pc_en,
   output logic               i_or_d,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               alusrc_a,
   output logic [1:0]         alusrc_b,
   output logic [2:0]         alu_control,
   output logic [1:0]         pc_src,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state
);

   state_t state_q;
   state_t state_d;

   logic   pc_write;
   logic   branch;
   logic   mem_write_s;
   logic   ir_write_s;
   logic   reg_write_s;
   logic   op_bad;
   logic   bad_funct;
   aluop_t aluop;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      op_bad  = 1'b0;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEXEC;
               OP_J:         state_d = S_JUMP;
               default:      op_bad  = 1'b1;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW)      state_d = S_MEMRD;
            else if (op == OP_SW) state_d = S_MEMWR;
         end
         S_MEMRD:    state_d = S_MEMWB;
         S_EXECUTE:  state_d = S_ALUWB;
         S_ADDIEXEC: state_d = S_ADDIWB;
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pc_write    = 1'b0;
      branch      = 1'b0;
      i_or_d      = 1'b0;
      mem_write_s = 1'b0;
      ir_write_s  = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write_s = 1'b0;
      alusrc_a    = 1'b0;
      alusrc_b    = 2'b00;
      aluop       = ALUOP_ADD;
      pc_src      = 2'b00;
      case (state_q)
         S_FETCH: begin
            ir_write_s = 1'b1;
            pc_write   = 1'b1;
            alusrc_b   = 2'b01;
         end
         S_DECODE: alusrc_b = 2'b11;
         S_MEMADR, S_ADDIEXEC: begin
            alusrc_a = 1'b1;
            alusrc_b = 2'b10;
         end
         S_MEMRD: i_or_d = 1'b1;
         S_MEMWB: begin
            mem_to_reg  = 1'b1;
            reg_write_s = 1'b1;
         end
         S_MEMWR: begin
            i_or_d      = 1'b1;
            mem_write_s = 1'b1;
         end
         S_EXECUTE: begin
            alusrc_a = 1'b1;
            aluop    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_dst     = 1'b1;
            reg_write_s = 1'b1;
         end
         S_ADDIWB: reg_write_s = 1'b1;
         S_BRANCH: begin
            alusrc_a = 1'b1;
            aluop    = ALUOP_SUB;
            pc_src   = 2'b01;
            branch   = 1'b1;
         end
         S_JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         default: pc_write = 1'b0;
      endcase
   end

   alu_decoder u_alu_decoder (
      .aluop       (aluop),
      .funct       (funct),
      .alu_control (alu_control),
      .bad_funct   (bad_funct)
   );

   // Write strobes are gated by reset so an abandoned instruction never commits.
   assign pc_en      = reset & (pc_write | (branch & zero));
   assign ir_write   = reset & ir_write_s;
   assign mem_write  = reset & mem_write_s;
   assign reg_write  = reset & reg_write_s;
   assign illegal_op = reset & (op_bad |
                                ((state_q == S_EXECUTE) & bad_funct));
   assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
// Inputs change on the falling edge; outputs are checked there too.
module tb_multicycle_controller;
   import mips_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pc_en;
   logic       i_or_d;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       alusrc_a;
   logic [1:0] alusrc_b;
   logic [2:0] alu_control;
   logic [1:0] pc_src;
   logic       illegal_op;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.STATE_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .op          (op),
      .funct       (funct),
      .zero        (zero),
      .pc_en       (pc_en),
      .i_or_d      (i_or_d),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .reg_dst     (reg_dst),
      .mem_to_reg  (mem_to_reg),
      .reg_write   (reg_write),
      .alusrc_a    (alusrc_a),
      .alusrc_b    (alusrc_b),
      .alu_control (alu_control),
      .pc_src      (pc_src),
      .illegal_op  (illegal_op),
      .state       (state)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      op    = OP_SW;
      funct = 6'd0;
      zero  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (state !== S_FETCH)
            $display("FAIL reset_state: got %0d expected %0d", state, S_FETCH);
         checks++;
         if ({mem_write, reg_write, ir_write, pc_en} !== 4'b0000)
            $display("FAIL reset_strobes: got %b expected 0000",
                     {mem_write, reg_write, ir_write, pc_en});
         if (state !== S_FETCH ||
             {mem_write, reg_write, ir_write, pc_en} !== 4'b0000)
            errors++;
      end
      reset = 1'b1;
      #1;
      checks++;
      if (state !== S_FETCH || ir_write !== 1'b1 || pc_en !== 1'b1) begin
         errors++;
         $display("FAIL first_fetch: got st=%0d ir=%b pc=%b expected 0 1 1",
                  state, ir_write, pc_en);
      end
   endtask

   task automatic test_lw();
      state_t exp_st [5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
      op = OP_LW;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         checks++;
         if (state !== exp_st[i]) begin
            errors++;
            $display("FAIL lw_state%0d: got %0d expected %0d",
                     i, state, exp_st[i]);
         end
         checks++;
         if (reg_write !== (i == 4)) begin
            errors++;
            $display("FAIL lw_reg_write%0d: got %b expected %b",
                     i, reg_write, i == 4);
         end
      end
      checks++;
      if (mem_to_reg !== 1'b1 || reg_dst !== 1'b0) begin
         errors++;
         $display("FAIL lw_wb: got m2r=%b dst=%b expected 1 0",
                  mem_to_reg, reg_dst);
      end
      step();
      checks++;
      if (state !== S_FETCH) begin
         errors++;
         $display("FAIL lw_done: got %0d expected %0d", state, S_FETCH);
      end
   endtask

   task automatic test_rtype();
      op    = OP_RTYPE;
      funct = FN_SLT;
      checks++;
      if (alusrc_b !== 2'b01 || alu_control !== ALU_ADD) begin
         errors++;
         $display("FAIL rt_fetch: got srcb=%b alu=%b expected 01 010",
                  alusrc_b, alu_control);
      end
      step();
      checks++;
      if (state !== S_DECODE || alusrc_b !== 2'b11) begin
         errors++;
         $display("FAIL rt_decode: got st=%0d srcb=%b expected 1 11",
                  state, alusrc_b);
      end
      step();
      checks++;
      if (state !== S_EXECUTE || alu_control !== ALU_SLT ||
          alusrc_a !== 1'b1 || alusrc_b !== 2'b00) begin
         errors++;
         $display("FAIL rt_exec: got st=%0d alu=%b a=%b b=%b expected 6 111 1 00",
                  state, alu_control, alusrc_a, alusrc_b);
      end
      step();
      checks++;
      if (state !== S_ALUWB || reg_dst !== 1'b1 || reg_write !== 1'b1) begin
         errors++;
         $display("FAIL rt_wb: got st=%0d dst=%b rw=%b expected 7 1 1",
                  state, reg_dst, reg_write);
      end
      step();
      checks++;
      if (state !== S_FETCH) begin
         errors++;
         $display("FAIL rt_done: got %0d expected %0d", state, S_FETCH);
      end
   endtask

   task automatic test_bad_funct();
      op    = OP_RTYPE;
      funct = 6'b111111;
      step();
      step();
      checks++;
      if (state !== S_EXECUTE || illegal_op !== 1'b1 ||
          alu_control !== ALU_ADD) begin
         errors++;
         $display("FAIL bad_funct: got st=%0d ill=%b alu=%b expected 6 1 010",
                  state, illegal_op, alu_control);
      end
      step();
      step();
   endtask

   task automatic test_beq();
      logic z_val [2] = '{1'b1, 1'b0};
      op = OP_BEQ;
      for (int r = 0; r < 2; r++) begin
         zero = z_val[r];
         step();
         step();
         checks++;
         if (state !== S_BRANCH || pc_src !== 2'b01 ||
             alu_control !== ALU_SUB || pc_en !== z_val[r]) begin
            errors++;
            $display("FAIL beq_z%0d: got st=%0d src=%b alu=%b en=%b expected 8 01 110 %b",
                     z_val[r], state, pc_src, alu_control, pc_en, z_val[r]);
         end
         step();
         checks++;
         if (state !== S_FETCH) begin
            errors++;
            $display("FAIL beq_done%0d: got %0d expected %0d",
                     r, state, S_FETCH);
         end
      end
      zero = 1'b0;
   endtask

   task automatic test_addi_jump();
      op = OP_ADDI;
      step();
      step();
      checks++;
      if (state !== S_ADDIEXEC || alusrc_a !== 1'b1 || alusrc_b !== 2'b10) begin
         errors++;
         $display("FAIL addi_exec: got st=%0d a=%b b=%b expected 9 1 10",
                  state, alusrc_a, alusrc_b);
      end
      step();
      checks++;
      if (state !== S_ADDIWB || reg_write !== 1'b1 || reg_dst !== 1'b0) begin
         errors++;
         $display("FAIL addi_wb: got st=%0d rw=%b dst=%b expected 10 1 0",
                  state, reg_write, reg_dst);
      end
      step();
      op = OP_J;
      step();
      step();
      checks++;
      if (state !== S_JUMP || pc_en !== 1'b1 || pc_src !== 2'b10) begin
         errors++;
         $display("FAIL jump: got st=%0d en=%b src=%b expected 11 1 10",
                  state, pc_en, pc_src);
      end
      step();
      checks++;
      if (state !== S_FETCH) begin
         errors++;
         $display("FAIL jump_done: got %0d expected %0d", state, S_FETCH);
      end
   endtask

   task automatic test_illegal();
      op = 6'b111111;
      step();
      checks++;
      if (state !== S_DECODE || illegal_op !== 1'b1 ||
          {mem_write, reg_write, ir_write, pc_en} !== 4'b0000) begin
         errors++;
         $display("FAIL illegal_decode: got st=%0d ill=%b wr=%b expected 1 1 0000",
                  state, illegal_op, {mem_write, reg_write, ir_write, pc_en});
      end
      step();
      checks++;
      if (state !== S_FETCH || illegal_op !== 1'b0) begin
         errors++;
         $display("FAIL illegal_next: got st=%0d ill=%b expected 0 0",
                  state, illegal_op);
      end
   endtask

   task automatic test_sw_reset();
      op = OP_SW;
      step();
      step();
      step();
      checks++;
      if (state !== S_MEMWR || mem_write !== 1'b1 || i_or_d !== 1'b1) begin
         errors++;
         $display("FAIL sw_memwr: got st=%0d mw=%b iod=%b expected 5 1 1",
                  state, mem_write, i_or_d);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (mem_write !== 1'b0) begin
         errors++;
         $display("FAIL sw_reset_mw: got %b expected 0", mem_write);
      end
      step();
      checks++;
      if (state !== S_FETCH || ir_write !== 1'b0) begin
         errors++;
         $display("FAIL sw_reset_next: got st=%0d ir=%b expected 0 0",
                  state, ir_write);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (ir_write !== 1'b1 || pc_en !== 1'b1) begin
         errors++;
         $display("FAIL sw_refetch: got ir=%b en=%b expected 1 1",
                  ir_write, pc_en);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_lw();
      test_rtype();
      test_bad_funct();
      test_beq();
      test_addi_jump();
      test_illegal();
      test_sw_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control unit for the multicycle MIPS core; drives every select and enable of the multicycle datapath.
Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback.
Inputs are the latched instruction fields (op, funct) and the ALU zero flag.
Handles lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.

Parameters:
STATE_W, 4, width of state register and of the debug state output

Ports:
clk  in  1  core clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag, current cycle
pc_en  out  1  PC load enable = pc_write | (branch & zero)
i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = Data register
reg_write  out  1  register file write
alusrc_a  out  1  0 = PC, 1 = register A
alusrc_b  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
pc_src  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
illegal_op  out  1  one-cycle pulse in DECODE for an unsupported op
state  out  STATE_W  current state, for debug only

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
- Transitions:
  - FETCH->DECODE.
  - DECODE->MEMADR (lw 100011, sw 101011); EXECUTE (000000); BRANCH (000100); ADDIEXEC (001000); JUMP (000010); any other op->FETCH with illegal_op=1.
  - MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB.
  - EXECUTE->ALUWB; ADDIEXEC->ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP->FETCH.
- Outputs are decoded combinationally from the registered state only. pc_en additionally uses zero. Every output not listed below is 0 in that state.
  - FETCH: ir_write=1, pc_write=1, alusrc_b=01, aluop=00.
  - DECODE: alusrc_b=11, aluop=00.
  - MEMADR and ADDIEXEC: alusrc_a=1, alusrc_b=10, aluop=00.
  - MEMRD: i_or_d=1.
  - MEMWB: mem_to_reg=1, reg_write=1.
  - MEMWR: i_or_d=1, mem_write=1.
  - EXECUTE: alusrc_a=1, alusrc_b=00, aluop=10.
  - ALUWB: reg_dst=1, reg_write=1.
  - ADDIWB: reg_write=1.
  - BRANCH: alusrc_a=1, aluop=01, pc_src=01, branch=1.
  - JUMP: pc_src=10, pc_write=1.
- ALU decode:
  - aluop 00 -> 010; aluop 01 -> 110.
  - aluop 10 decodes funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
  - An unknown funct gives 010, and illegal_op pulses in EXECUTE.
- Latency (cycles): lw 5; sw, R-type, addi 4; beq, j 3.
- Reset: while reset==0 at a clock edge, the next state is FETCH.
  - Combinationally, while reset==0, pc_en, ir_write, mem_write, reg_write and illegal_op are forced to 0.
  - When reset==0 arrives mid-instruction, that instruction is abandoned with no further writes.
  - The first FETCH is performed in the first cycle after reset returns to 1.
- beq with zero=0: pc_en=0 in BRANCH; the PC keeps PC+4, which was written in FETCH.

Decomposition:
- Package mips_pkg holds:
  - the state enum (STATE_W bits);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - funct constants;
  - aluop encodings and alu_control encodings.
- Sub-module alu_decoder: combinational (aluop, funct) -> (alu_control, bad_funct).

Test Plan:
- Hold reset=0 for 3 cycles, release -> state=FETCH, ir_write=1 and pc_en=1 in the first cycle after release; no mem_write/reg_write during reset.
- op=100011 (lw) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; reg_write=1 with mem_to_reg=1, reg_dst=0 only in cycle 5.
- op=000000, funct=101010 -> alu_control=111 in EXECUTE; ALUWB reg_dst=1, reg_write=1; back to FETCH after 4 cycles.
- op=000100, zero=1 then a repeat with zero=0 -> pc_en=1, pc_src=01 in BRANCH; second run pc_en=0.
- op=111111 -> illegal_op=1 for one cycle in DECODE, next state FETCH, no write strobes.
- sw in MEMWR with reset driven 0 -> mem_write=0 in that cycle, next state FETCH.
